uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter (sync_rs232_uart ena_tx/tx_data/tx_busy handshake) between NUM_REQ byte-stream requesters, e.g. CPU uartController path, boot logger, debug monitor. Round-robin arbitration with packet lock: a requester keeps the transmitter until it sends a byte flagged last. Sequences each byte as load, ena_tx pulse, wait for busy to rise, wait for busy to fall. Sits between the requesters and the UART core, replacing the direct ena_tx drive.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/rr_priority_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t          : byte-sequencing FSM encoding
//   DEFAULT_BUSY_WAIT    : default cycles to wait for tx_busy to rise
//   DEFAULT_LOCK_TIMEOUT : default idle cycles before a stuck lock is dropped
//   idx_width()          : width of a requester index (at least 1 bit)
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int DEFAULT_BUSY_WAIT    = 4;
    localparam int DEFAULT_LOCK_TIMEOUT = 1024;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority search.
//   req   : request vector
//   start : index with highest priority; search proceeds upward and wraps
//   found : at least one request is set
//   idx   : first set request at or after start (0 when none)
module rr_priority_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      start,
    output logic               found,
    output logic [IW-1:0]      idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan farthest offset first so the nearest set request overwrites it.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[(int'(start) + off) % NUM_REQ]) begin
                found = 1'b1;
                idx   = IW'((int'(start) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters.
// Round-robin arbitration with packet lock: the granted requester keeps the
// transmitter until a byte flagged last is accepted. Each byte is sequenced
// as accept/load, one-cycle ena_tx pulse, wait for tx_busy to rise (bounded
// by BUSY_WAIT cycles), then wait for tx_busy to fall.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req_valid/data/last  : per-requester byte stream (data at [8i+7:8i])
//   req_ready            : one-hot accept, transfer on valid & ready
//   ena_tx, tx_data      : start pulse and byte to the UART core
//   tx_busy              : UART transmitter busy
//   grant_id             : current / last granted requester
//   lock_active          : packet lock held by grant_id
//
// Optional build macro UART_TX_ARB_LOCK_TIMEOUT_EN: drops a held lock after
// LOCK_TIMEOUT idle cycles in which the lock owner presents no byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int BUSY_WAIT    = DEFAULT_BUSY_WAIT,
    parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*8-1:0]            req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            ena_tx,
    output logic [7:0]                      tx_data,
    input  logic                            tx_busy,
    output logic [idx_width(NUM_REQ)-1:0]   grant_id,
    output logic                            lock_active
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int WW = $clog2(BUSY_WAIT + 1);

    arb_state_t    state, state_d;
    logic [WW-1:0] wait_cnt, wait_cnt_d;
    logic [IW-1:0] start_idx, rr_idx, cand;
    logic          rr_found, cand_valid, cand_last, accept, lock_expire;
    logic [7:0]    cand_data;

    // Rotating priority starts just after the last grant.
    assign start_idx = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req   (req_valid),
        .start (start_idx),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Under lock only the owner may be served, even while it has nothing.
    always_comb begin
        cand       = lock_active ? grant_id : rr_idx;
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        cand_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand == IW'(i)) begin
                cand_valid = req_valid[i];
                cand_last  = req_last[i];
                cand_data  = req_data[i*8 +: 8];
            end
        end
        if (!lock_active && !rr_found) begin
            cand_valid = 1'b0;
        end
    end

    assign accept = (state == IDLE) && !tx_busy && cand_valid;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (cand == IW'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                state_d    = WAIT_BUSY;
                wait_cnt_d = '0;
            end
            WAIT_BUSY: begin
                // A UART that never raises busy must not stall the arbiter.
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    wait_cnt_d = wait_cnt + WW'(1);
                    if (wait_cnt_d == WW'(BUSY_WAIT)) state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ena_tx = (state == START);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            tx_data     <= '0;
            grant_id    <= '0;
            lock_active <= 1'b0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            if (accept) begin
                tx_data     <= cand_data;
                grant_id    <= cand;
                lock_active <= ~cand_last;
            end else if (lock_expire) begin
                lock_active <= 1'b0;
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);

    logic [LW-1:0] lock_cnt;
    logic          lock_stall;

    // Owner holds the lock but offers nothing while the arbiter is idle.
    assign lock_stall  = (state == IDLE) && lock_active && !cand_valid;
    assign lock_expire = lock_stall && (lock_cnt == LW'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (accept || lock_expire) begin
            lock_cnt <= '0;
        end else if (lock_stall) begin
            lock_cnt <= lock_cnt + LW'(1);
        end
    end
`else
    logic unused_lock_timeout;
    assign unused_lock_timeout = ^LOCK_TIMEOUT;
    assign lock_expire         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 3;
    localparam int IW      = 2;
    localparam int DEPTH   = 512;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*8-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   ena_tx;
    logic [7:0]             tx_data;
    logic                   tx_busy;
    logic [IW-1:0]          grant_id;
    logic                   lock_active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_WAIT    (4),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .ena_tx      (ena_tx),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .lock_active (lock_active)
    );

    // UART model: busy rises the cycle after ena_tx and lasts busy_len cycles
    // (busy_len 0 models a UART that never reports busy).
    int   busy_len = 10;
    int   bcnt     = 0;
    logic ext_busy = 1'b0;

    always @(posedge clk) begin
        if (ena_tx && busy_len > 0) bcnt <= busy_len;
        else if (bcnt > 0)          bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0) || ext_busy;

    // Per-requester byte streams: {last, data}
    logic [8:0] mem [NUM_REQ][DEPTH];
    int head [NUM_REQ] = '{default: 0};
    int tail [NUM_REQ] = '{default: 0};

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
        logic       lock;
    } exp_t;

    exp_t sb[$];
    int   gaps[$];
    int   checks  = 0;
    int   errors  = 0;
    int   acc_cnt = 0;

    // Reference model state
    int m_ptr [NUM_REQ] = '{default: 0};
    int m_last = 0;
    bit m_lock = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r] % DEPTH] = {l, d};
        tail[r]++;
    endtask

    // Packet-level arbitration model: with every loaded stream presenting
    // its next byte continuously, emit the byte order the arbiter must use.
    task automatic run_model();
        int   pick;
        exp_t e;
        while (1) begin
            pick = -1;
            if (m_lock) begin
                if (m_ptr[m_last] != tail[m_last]) pick = m_last;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (pick < 0 && m_ptr[(m_last + k) % NUM_REQ] != tail[(m_last + k) % NUM_REQ])
                        pick = (m_last + k) % NUM_REQ;
                end
            end
            if (pick < 0) break;
            e.id   = 8'(pick);
            e.data = mem[pick][m_ptr[pick] % DEPTH][7:0];
            e.lock = ~mem[pick][m_ptr[pick] % DEPTH][8];
            m_ptr[pick]++;
            m_last = pick;
            m_lock = e.lock;
            sb.push_back(e);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NUM_REQ; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!(all_empty() && sb.size() == 0 && bcnt == 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, (n < budget) ? 0 : 1, 0);
        repeat (8) @(posedge clk);
        #2;
    endtask

    // Requester drivers: present the head byte, advance after an accept.
    initial begin : driver
        logic [NUM_REQ-1:0] rdy;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && rdy[i]) head[i]++;
                if (head[i] != tail[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*8 +: 8]  = mem[i][head[i] % DEPTH][7:0];
                    req_last[i]         = mem[i][head[i] % DEPTH][8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ena_tx pulse.
    int cycle    = 0;
    int last_ena = 0;
    bit prev_acc = 1'b0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                prev_acc = 1'b0;
            end else begin
                if (req_ready != '0) begin
                    check("ready_onehot", $countones(req_ready), 1);
                    check("ready_while_busy", int'(tx_busy), 0);
                end
                if (ena_tx) begin
                    check("ena_one_cycle_after_accept", int'(prev_acc), 1);
                    check("ena_has_expected_byte", (sb.size() > 0) ? 1 : 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("tx_data", int'(tx_data), int'(e.data));
                        check("grant_id", int'(grant_id), int'(e.id));
                        check("lock_active", int'(lock_active), int'(e.lock));
                    end
                    gaps.push_back(cycle - last_ena);
                    last_ena = cycle;
                end
                prev_acc = |(req_valid & req_ready);
                if (prev_acc) acc_cnt++;
            end
        end
    end

    initial begin : main
        int n;
        exp_t e;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ena_tx", int'(ena_tx), 0);
        check("reset_tx_data", int'(tx_data), 0);
        check("reset_grant_id", int'(grant_id), 0);
        check("reset_lock_active", int'(lock_active), 0);
        check("reset_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Single byte from requester 0
        busy_len = 10;
        gaps.delete();
        acc_cnt = 0;
        push_byte(0, 8'h41, 1'b1);
        run_model();
        drain("single", 200);
        check("single_ena_count", gaps.size(), 1);
        check("single_accept_count", acc_cnt, 1);

        // Req0 and req2 together after grant 0: req2 first, then req0
        gaps.delete();
        push_byte(0, 8'h50, 1'b1);
        push_byte(2, 8'h52, 1'b1);
        run_model();
        drain("rr_0_2", 300);
        check("rr_ena_count", gaps.size(), 2);
        if (gaps.size() == 2) check("busy10_spacing", gaps[1], 13);

        // Req1 and req2 together after grant 0: req1 first
        push_byte(1, 8'h61, 1'b1);
        push_byte(2, 8'h62, 1'b1);
        run_model();
        drain("rr_1_2", 300);

        // Packet lock: req1 three-byte packet while req0 waits
        push_byte(0, 8'h33, 1'b1);
        run_model();
        drain("pre_lock", 200);
        push_byte(1, 8'h10, 1'b0);
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h12, 1'b1);
        push_byte(0, 8'h20, 1'b1);
        run_model();
        drain("lock", 400);

        // UART never raises busy: bounded wait, then proceed
        busy_len = 0;
        gaps.delete();
        push_byte(0, 8'hA0, 1'b1);
        push_byte(0, 8'hA1, 1'b1);
        run_model();
        drain("no_busy", 200);
        check("no_busy_ena_count", gaps.size(), 2);
        if (gaps.size() == 2) check("no_busy_spacing", gaps[1], 7);

        // External UART user holds busy in IDLE: no accept until released
        busy_len = 3;
        ext_busy = 1'b1;
        gaps.delete();
        push_byte(2, 8'hC5, 1'b1);
        run_model();
        repeat (10) @(posedge clk);
        #2;
        check("ext_busy_not_accepted", tail[2] - head[2], 1);
        check("ext_busy_no_ena", gaps.size(), 0);
        ext_busy = 1'b0;
        drain("ext_busy", 200);

        // Reset while waiting for busy to fall
        busy_len = 10;
        push_byte(1, 8'h5A, 1'b1);
        run_model();
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("reset_test_ena_timeout", (n < 100) ? 0 : 1, 0);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        check("midreset_ena_tx", int'(ena_tx), 0);
        check("midreset_tx_data", int'(tx_data), 0);
        check("midreset_grant_id", int'(grant_id), 0);
        check("midreset_lock_active", int'(lock_active), 0);
        gaps.delete();
        repeat (20) @(posedge clk);
        #2;
        check("midreset_no_ena", gaps.size(), 0);
        m_last = 0;
        m_lock = 1'b0;
        drain("post_reset", 200);

        // Randomized packet batches
        for (int b = 0; b < 12; b++) begin
            int npk, len;
            busy_len = $urandom_range(0, 8);
            for (int r = 0; r < NUM_REQ; r++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 3);
                    for (int k = 0; k < len; k++)
                        push_byte(r, 8'($urandom), (k == len - 1));
                end
            end
            run_model();
            drain("random", 3000);
        end

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
        // Lock owner goes quiet: lock released after the timeout
        busy_len = 3;
        push_byte(1, 8'h77, 1'b0);
        run_model();
        n = 0;
        while (!lock_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_lock_seen", int'(lock_active), 1);
        #1;
        push_byte(0, 8'h55, 1'b1);
        e.id   = 8'd0;
        e.data = 8'h55;
        e.lock = 1'b0;
        sb.push_back(e);
        m_ptr[0] = tail[0];
        m_last   = 0;
        m_lock   = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("timeout_lock_still_held", int'(lock_active), 1);
        check("timeout_req0_blocked", tail[0] - head[0], 1);
        drain("timeout", 300);
        check("timeout_lock_released", int'(lock_active), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
